pipe_stage_chain: RTL and testbench

Parametrised pipeline register chain that carries a payload (PC, or PC plus instruction) through `STAGES` back-to-back stage registers. Each stage has its own valid bit. The chain supports stall-from-stage-k with bubble insertion, flush of all younger stages, and retire/occupancy counters. It replaces the fixed hand-wired IF/ID/EX/MEM/WB register chain in the ARM core top as the single generic stage-register fabric, and adds the stall, flush and bubble behaviour that chain does not have.

---
 rtl/pipe_stage_chain_pkg.sv | 24 ++
 rtl/pipe_stage_chain_if.sv | 34 +++
 rtl/pipe_stage_reg.sv | 61 ++++++
 rtl/pipe_stage_chain.sv | 94 +++++++++
 tb/tb_pipe_stage_chain.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_chain_pkg.sv
// Shared constants, slot type and popcount helper for the generic
// pipeline stage-register chain.
package pipe_pkg;

    localparam int unsigned PIPE_MAX_STAGES = 16;
    localparam int unsigned PIPE_DEF_WIDTH  = 32;
    localparam int unsigned PIPE_DEF_STAGES = 4;
    localparam int unsigned PIPE_DEF_CNT_W  = 32;

    typedef struct packed {
        logic        valid;
        logic [31:0] data;
    } pipe_slot_t;

    function automatic logic [4:0] pipe_popcount(input logic [PIPE_MAX_STAGES-1:0] vec);
        logic [4:0] cnt;
        cnt = 5'd0;
        for (int i = 0; i < PIPE_MAX_STAGES; i++) begin
            cnt = cnt + {4'd0, vec[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/pipe_stage_chain_if.sv
// Handshake, control and observation bundle of the stage-register chain;
// master is the upstream/controller side, slave is the chain itself.
interface pipe_stage_chain_if import pipe_pkg::*; #(
    parameter int unsigned WIDTH  = PIPE_DEF_WIDTH,
    parameter int unsigned STAGES = PIPE_DEF_STAGES,
    parameter int unsigned CNT_W  = PIPE_DEF_CNT_W
);
    localparam int unsigned IDX_W = $clog2(STAGES);

    logic                      in_valid;
    logic [WIDTH-1:0]          in_data;
    logic                      in_ready;
    logic                      stall_en;
    logic [IDX_W-1:0]          stall_idx;
    logic                      flush_en;
    logic [IDX_W-1:0]          flush_idx;
    logic [STAGES-1:0]         stage_valid;
    logic [STAGES*WIDTH-1:0]   stage_data;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [IDX_W:0]            occupancy;
    logic [CNT_W-1:0]          retire_cnt;

    modport master (
        output in_valid, in_data, stall_en, stall_idx, flush_en, flush_idx,
        input  in_ready, stage_valid, stage_data, out_valid, out_data, occupancy, retire_cnt
    );

    modport slave (
        input  in_valid, in_data, stall_en, stall_idx, flush_en, flush_idx,
        output in_ready, stage_valid, stage_data, out_valid, out_data, occupancy, retire_cnt
    );

endinterface

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: payload plus valid bit, with flush > hold > load >
// bubble > shift priority on the next state.
module pipe_stage_reg import pipe_pkg::*; #(
    parameter int unsigned WIDTH = PIPE_DEF_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             hold_i,
    input  logic             bubble_i,
    input  logic             load_i,
    input  logic             in_valid_i,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             prev_valid_i,
    input  logic [WIDTH-1:0] prev_data_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] data_o,
    output logic             next_valid_o
);

    logic             valid_d, valid_q;
    logic [WIDTH-1:0] data_d, data_q;

    // Next-state selection; a flush clears only the valid bit.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (flush_i) begin
            valid_d = 1'b0;
            data_d  = data_q;
        end else if (hold_i) begin
            valid_d = valid_q;
            data_d  = data_q;
        end else if (load_i) begin
            valid_d = in_valid_i;
            data_d  = in_data_i;
        end else if (bubble_i) begin
            valid_d = 1'b0;
            data_d  = '0;
        end else begin
            valid_d = prev_valid_i;
            data_d  = prev_data_i;
        end
    end

    // Stage state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o      = valid_q;
    assign data_o       = data_q;
    assign next_valid_o = valid_d;

endmodule

// File: rtl/pipe_stage_chain.sv
// Generic stage-register chain with stall/bubble, younger-stage flush,
// occupancy and retire counting. Stage 0 is youngest.
module pipe_stage_chain import pipe_pkg::*; #(
    parameter int unsigned WIDTH  = PIPE_DEF_WIDTH,
    parameter int unsigned STAGES = PIPE_DEF_STAGES,
    parameter int unsigned CNT_W  = PIPE_DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST,
    pipe_stage_chain_if.slave bus
);

    localparam int unsigned      IDX_W    = $clog2(STAGES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STAGES - 1);

    logic [IDX_W-1:0]             si_s, fi_s;
    logic [STAGES-1:0]            hold_s, flush_s, bubble_s, load_s;
    logic [STAGES-1:0]            prev_valid_s, valid_s, next_valid_s;
    logic [STAGES-1:0][WIDTH-1:0] prev_data_s, data_s;
    logic                         retire_s;
    logic [IDX_W:0]               occ_d, occ_q;
    logic [CNT_W-1:0]             retire_d, retire_q;

    // Saturate indices, decode hold/flush ranges and wire stage-to-stage data.
    always_comb begin
        si_s         = (bus.stall_idx > LAST_IDX) ? LAST_IDX : bus.stall_idx;
        fi_s         = (bus.flush_idx > LAST_IDX) ? LAST_IDX : bus.flush_idx;
        hold_s       = '0;
        flush_s      = '0;
        bubble_s     = '0;
        load_s       = '0;
        prev_valid_s = '0;
        prev_data_s  = '0;
        load_s[0]    = 1'b1;
        for (int i = 0; i < STAGES; i++) begin
            hold_s[i]  = bus.stall_en && (i <= int'(si_s));
            flush_s[i] = bus.flush_en && (i <= int'(fi_s));
        end
        for (int i = 1; i < STAGES; i++) begin
            bubble_s[i]     = hold_s[i-1] && !hold_s[i];
            prev_valid_s[i] = valid_s[i-1];
            prev_data_s[i]  = data_s[i-1];
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        pipe_stage_reg #(.WIDTH(WIDTH)) u_stage (
            .clk_i        (CLK),
            .rst_ni       (RST),
            .flush_i      (flush_s[g]),
            .hold_i       (hold_s[g]),
            .bubble_i     (bubble_s[g]),
            .load_i       (load_s[g]),
            .in_valid_i   (bus.in_valid),
            .in_data_i    (bus.in_data),
            .prev_valid_i (prev_valid_s[g]),
            .prev_data_i  (prev_data_s[g]),
            .valid_o      (valid_s[g]),
            .data_o       (data_s[g]),
            .next_valid_o (next_valid_s[g])
        );
    end

    // A payload retires when the oldest stage empties without being flushed.
    always_comb begin
        retire_s = valid_s[STAGES-1] && !hold_s[STAGES-1] && !(bus.flush_en && (fi_s == LAST_IDX));
        occ_d    = (IDX_W+1)'(pipe_popcount(PIPE_MAX_STAGES'(next_valid_s)));
        if (retire_s) begin
            retire_d = retire_q + CNT_W'(1);
        end else begin
            retire_d = retire_q;
        end
    end

    // Occupancy and retire counters, updated with the valid bits.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            occ_q    <= '0;
            retire_q <= '0;
        end else begin
            occ_q    <= occ_d;
            retire_q <= retire_d;
        end
    end

    assign bus.in_ready    = !bus.stall_en;
    assign bus.stage_valid = valid_s;
    assign bus.stage_data  = data_s;
    assign bus.out_valid   = valid_s[STAGES-1];
    assign bus.out_data    = data_s[STAGES-1];
    assign bus.occupancy   = occ_q;
    assign bus.retire_cnt  = retire_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: a 4-stage chain driven from a vector table, plus a 3-stage
// chain with a 4-bit retire counter for saturation, flush and wrap sequences.
module tb_pipe_stage_chain;
    import pipe_pkg::*;

    typedef struct {
        logic        iv;
        logic [31:0] id;
        logic        se;
        logic [1:0]  sidx;
        logic        fe;
        logic [1:0]  fidx;
        logic [3:0]  ev;
        logic [31:0] eout;
        logic [2:0]  eocc;
        logic [31:0] eret;
        logic        erdy;
        logic [31:0] es0;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    vec_t vt[11];

    always #5 clk = ~clk;

    pipe_stage_chain_if #(.WIDTH(32), .STAGES(4), .CNT_W(32)) bus4 ();
    pipe_stage_chain_if #(.WIDTH(32), .STAGES(3), .CNT_W(4))  bus3 ();

    pipe_stage_chain #(.WIDTH(32), .STAGES(4), .CNT_W(32)) u4 (.CLK(clk), .RST(rst_n), .bus(bus4));
    pipe_stage_chain #(.WIDTH(32), .STAGES(3), .CNT_W(4))  u3 (.CLK(clk), .RST(rst_n), .bus(bus3));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive4(input logic iv, input logic [31:0] id, input logic se,
                          input logic [1:0] sidx, input logic fe, input logic [1:0] fidx);
        bus4.in_valid  = iv;
        bus4.in_data   = id;
        bus4.stall_en  = se;
        bus4.stall_idx = sidx;
        bus4.flush_en  = fe;
        bus4.flush_idx = fidx;
    endtask

    task automatic drive3(input logic iv, input logic [31:0] id, input logic se,
                          input logic [1:0] sidx, input logic fe, input logic [1:0] fidx);
        bus3.in_valid  = iv;
        bus3.in_data   = id;
        bus3.stall_en  = se;
        bus3.stall_idx = sidx;
        bus3.flush_en  = fe;
        bus3.flush_idx = fidx;
    endtask

    initial begin
        drive4(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        drive3(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);

        // iv id se sidx fe fidx | valid out occ ret rdy s0
        vt[0]  = '{1'b1, 32'd0,  1'b0, 2'd0, 1'b0, 2'd0, 4'b0001, 32'd0,  3'd1, 32'd0, 1'b1, 32'd0};
        vt[1]  = '{1'b1, 32'd4,  1'b0, 2'd0, 1'b0, 2'd0, 4'b0011, 32'd0,  3'd2, 32'd0, 1'b1, 32'd4};
        vt[2]  = '{1'b1, 32'd8,  1'b0, 2'd0, 1'b0, 2'd0, 4'b0111, 32'd0,  3'd3, 32'd0, 1'b1, 32'd8};
        vt[3]  = '{1'b1, 32'd12, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 32'd0,  3'd4, 32'd0, 1'b1, 32'd12};
        vt[4]  = '{1'b1, 32'd16, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 32'd4,  3'd4, 32'd1, 1'b1, 32'd16};
        vt[5]  = '{1'b1, 32'd20, 1'b1, 2'd1, 1'b0, 2'd0, 4'b1011, 32'd8,  3'd3, 32'd2, 1'b0, 32'd16};
        vt[6]  = '{1'b1, 32'd20, 1'b1, 2'd1, 1'b0, 2'd0, 4'b0011, 32'd0,  3'd2, 32'd3, 1'b0, 32'd16};
        vt[7]  = '{1'b1, 32'd20, 1'b0, 2'd0, 1'b0, 2'd0, 4'b0111, 32'd0,  3'd3, 32'd3, 1'b1, 32'd20};
        vt[8]  = '{1'b1, 32'd24, 1'b0, 2'd0, 1'b0, 2'd0, 4'b1111, 32'd12, 3'd4, 32'd3, 1'b1, 32'd24};
        vt[9]  = '{1'b1, 32'd28, 1'b1, 2'd1, 1'b1, 2'd2, 4'b1000, 32'd16, 3'd1, 32'd4, 1'b0, 32'd24};
        vt[10] = '{1'b0, 32'd0,  1'b0, 2'd0, 1'b0, 2'd0, 4'b0000, 32'd16, 3'd0, 32'd5, 1'b1, 32'd0};

        repeat (2) @(posedge clk);
        #1;
        check("reset_valid", 64'(bus4.stage_valid), 64'd0);
        check("reset_occ",   64'(bus4.occupancy),   64'd0);
        check("reset_ret",   64'(bus4.retire_cnt),  64'd0);
        check("reset_out",   64'(bus4.out_data),    64'd0);
        check("reset_outv",  64'(bus4.out_valid),   64'd0);
        rst_n = 1'b1;

        for (int k = 0; k < 11; k++) begin
            drive4(vt[k].iv, vt[k].id, vt[k].se, vt[k].sidx, vt[k].fe, vt[k].fidx);
            tick();
            check($sformatf("v%0d_valid", k), 64'(bus4.stage_valid),       64'(vt[k].ev));
            check($sformatf("v%0d_outv", k),  64'(bus4.out_valid),         64'(vt[k].ev[3]));
            check($sformatf("v%0d_out", k),   64'(bus4.out_data),          64'(vt[k].eout));
            check($sformatf("v%0d_occ", k),   64'(bus4.occupancy),         64'(vt[k].eocc));
            check($sformatf("v%0d_ret", k),   64'(bus4.retire_cnt),        64'(vt[k].eret));
            check($sformatf("v%0d_rdy", k),   64'(bus4.in_ready),          64'(vt[k].erdy));
            check($sformatf("v%0d_s0", k),    64'(bus4.stage_data[31:0]),  64'(vt[k].es0));
        end

        // 3-stage chain: fill, then out-of-range stall index holds every stage.
        for (int k = 0; k < 3; k++) begin
            drive3(1'b1, 32'd100 + 32'(k), 1'b0, 2'd0, 1'b0, 2'd0);
            tick();
        end
        check("s3_fill_valid", 64'(bus3.stage_valid), 64'h7);
        check("s3_fill_out",   64'(bus3.out_data),    64'd100);
        check("s3_fill_ret",   64'(bus3.retire_cnt),  64'd0);
        for (int k = 0; k < 2; k++) begin
            drive3(1'b1, 32'd103, 1'b1, 2'd3, 1'b0, 2'd0);
            tick();
            check("s3_stall_valid", 64'(bus3.stage_valid),      64'h7);
            check("s3_stall_out",   64'(bus3.out_data),         64'd100);
            check("s3_stall_s0",    64'(bus3.stage_data[31:0]), 64'd102);
            check("s3_stall_ret",   64'(bus3.retire_cnt),       64'd0);
            check("s3_stall_rdy",   64'(bus3.in_ready),         64'd0);
        end
        drive3(1'b1, 32'd104, 1'b0, 2'd0, 1'b1, 2'd3);
        tick();
        check("s3_flush_valid", 64'(bus3.stage_valid),      64'd0);
        check("s3_flush_ret",   64'(bus3.retire_cnt),       64'd0);
        check("s3_flush_occ",   64'(bus3.occupancy),        64'd0);
        check("s3_flush_s0",    64'(bus3.stage_data[31:0]), 64'd102);

        // 4-bit retire counter wraps after 16 retires.
        for (int k = 0; k < 16; k++) begin
            drive3(1'b1, 32'(k), 1'b0, 2'd0, 1'b0, 2'd0);
            tick();
        end
        check("wrap_ret13", 64'(bus3.retire_cnt), 64'd13);
        drive3(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        repeat (3) tick();
        check("wrap_ret0", 64'(bus3.retire_cnt), 64'd0);
        check("wrap_occ",  64'(bus3.occupancy),  64'd0);

        // Flushing a valid oldest stage never counts as a retire.
        for (int k = 0; k < 3; k++) begin
            drive3(1'b1, 32'd200 + 32'(k), 1'b0, 2'd0, 1'b0, 2'd0);
            tick();
        end
        check("fl_fill_valid", 64'(bus3.stage_valid), 64'h7);
        drive3(1'b0, 32'd0, 1'b0, 2'd0, 1'b1, 2'd2);
        tick();
        check("fl_valid", 64'(bus3.stage_valid), 64'd0);
        check("fl_ret",   64'(bus3.retire_cnt),  64'd0);
        drive3(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        repeat (3) tick();
        check("fl_ret_after", 64'(bus3.retire_cnt), 64'd0);

        // Mid-cycle reset while traffic and a stall are pending.
        drive4(1'b1, 32'h55, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        tick();
        drive4(1'b1, 32'h66, 1'b1, 2'd1, 1'b0, 2'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 64'(bus4.stage_valid),       64'd0);
        check("arst_data",  64'(bus4.stage_data == '0),  64'd1);
        check("arst_occ",   64'(bus4.occupancy),         64'd0);
        check("arst_ret",   64'(bus4.retire_cnt),        64'd0);
        check("arst_out",   64'(bus4.out_data),          64'd0);
        check("arst_outv",  64'(bus4.out_valid),         64'd0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        drive4(1'b1, 32'hABC, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        check("rel_valid", 64'(bus4.stage_valid), 64'h1);
        drive4(1'b0, 32'd0, 1'b0, 2'd0, 1'b0, 2'd0);
        tick();
        tick();
        check("rel_outv_early", 64'(bus4.out_valid), 64'd0);
        tick();
        check("rel_outv", 64'(bus4.out_valid),  64'd1);
        check("rel_out",  64'(bus4.out_data),   64'hABC);
        check("rel_ret",  64'(bus4.retire_cnt), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
